// File: rtl/sram_array_seq.sv
// sram_array_seq -- timing sequencer for the switch-level 6T SRAM array.
//
// Accepts one read/write request at a time (valid/ready), then steps the
// array controls through IDLE -> PRE -> ACC -> RESP so that precharge,
// wordline, write driver and sense amp never overlap. Every output is a
// flop whose next value is decoded from the next state.
//
// Optional feature: define SRAM_ARRAY_SEQ_WRITE_VERIFY_EN to follow every
// write with a PRE + read-ACC verify pass; resp_err flags a mismatch.
// Without it resp_err is tied to 0.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake
//   req_we/addr/wdata     request: 1 = write, row address, write data
//   resp_valid            one-cycle completion pulse
//   resp_rdata            last read data (held between reads)
//   resp_err              write-verify mismatch
//   pre_b                 active-low bitline precharge
//   wl                    one-hot wordlines
//   wr_en, wdata_drv      write driver enable / data
//   sae                   sense-amp enable
//   bl_sense              sense-amp outputs from the array
module sram_array_seq #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 32,
    parameter int PRE_CYC = 1,
    parameter int ACC_CYC = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    output logic                 resp_valid,
    output logic [DATA_W-1:0]    resp_rdata,
    output logic                 resp_err,
    output logic                 pre_b,
    output logic [2**ADDR_W-1:0] wl,
    output logic                 wr_en,
    output logic [DATA_W-1:0]    wdata_drv,
    output logic                 sae,
    input  logic [DATA_W-1:0]    bl_sense
);

    localparam int NWL   = 2 ** ADDR_W;
    localparam int CMAX  = (PRE_CYC > ACC_CYC) ? PRE_CYC : ACC_CYC;
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam logic [CNT_W-1:0] PRE_LD = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] ACC_LD = CNT_W'(ACC_CYC - 1);

    typedef enum logic [1:0] {IDLE, PRE, ACC, RESP} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic                vfy_q, vfy_d;      // current ACC is the verify read of a write
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                pre_b_q, pre_b_d;
    logic [NWL-1:0]      wl_q, wl_d;
    logic                wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wdata_drv_q, wdata_drv_d;
    logic                sae_q, sae_d;
    logic                acc_d, wr_phase_d;

`ifdef SRAM_ARRAY_SEQ_WRITE_VERIFY_EN
    logic                err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        vfy_d   = vfy_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef SRAM_ARRAY_SEQ_WRITE_VERIFY_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                // req_ready is always 1 here, so valid alone completes the handshake
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    vfy_d   = 1'b0;
                    cnt_d   = PRE_LD;
                    state_d = PRE;
`ifdef SRAM_ARRAY_SEQ_WRITE_VERIFY_EN
                    err_d   = 1'b0;
`endif
                end
            end
            PRE: begin
                if (cnt_q == '0) begin
                    cnt_d   = ACC_LD;
                    state_d = ACC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ACC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!we_q) rdata_d = bl_sense;
`ifdef SRAM_ARRAY_SEQ_WRITE_VERIFY_EN
                    if (we_q && !vfy_q) begin
                        // write done: re-precharge and read the row back
                        vfy_d   = 1'b1;
                        cnt_d   = PRE_LD;
                        state_d = PRE;
                    end else begin
                        if (vfy_q) err_d = (bl_sense != wdata_q);
                        state_d = RESP;
                    end
`else
                    state_d = RESP;
`endif
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Output flops are loaded from the next state so they line up with it.
        acc_d        = (state_d == ACC);
        wr_phase_d   = acc_d && we_d && !vfy_d;
        req_ready_d  = (state_d == IDLE);
        resp_valid_d = (state_d == RESP);
        pre_b_d      = acc_d;
        wl_d         = acc_d ? ({{(NWL-1){1'b0}}, 1'b1} << addr_d) : '0;
        wr_en_d      = wr_phase_d;
        wdata_drv_d  = wr_phase_d ? wdata_d : wdata_drv_q;
        sae_d        = acc_d && !wr_phase_d && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            vfy_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            pre_b_q      <= 1'b0;
            wl_q         <= '0;
            wr_en_q      <= 1'b0;
            wdata_drv_q  <= '0;
            sae_q        <= 1'b0;
`ifdef SRAM_ARRAY_SEQ_WRITE_VERIFY_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            vfy_q        <= vfy_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            pre_b_q      <= pre_b_d;
            wl_q         <= wl_d;
            wr_en_q      <= wr_en_d;
            wdata_drv_q  <= wdata_drv_d;
            sae_q        <= sae_d;
`ifdef SRAM_ARRAY_SEQ_WRITE_VERIFY_EN
            err_q        <= err_d;
`endif
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign pre_b      = pre_b_q;
    assign wl         = wl_q;
    assign wr_en      = wr_en_q;
    assign wdata_drv  = wdata_drv_q;
    assign sae        = sae_q;
`ifdef SRAM_ARRAY_SEQ_WRITE_VERIFY_EN
    assign resp_err   = err_q;
`else
    assign resp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_sram_array_seq.sv
// Directed bench for sram_array_seq with a response scoreboard: each
// accepted request pushes its expected response (data, err, cycle) and the
// negedge monitor pops/compares on resp_valid. Array invariants are checked
// every cycle.
module tb_sram_array_seq;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int NWL = 16;
`ifdef SRAM_ARRAY_SEQ_WRITE_VERIFY_EN
    localparam bit VFY = 1'b1;
`else
    localparam bit VFY = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_we = 1'b0;
    logic [AW-1:0]  req_addr = '0;
    logic [DW-1:0]  req_wdata = '0;
    logic [DW-1:0]  bl_sense = '0;
    logic           req_ready, resp_valid, resp_err, pre_b, wr_en, sae;
    logic [DW-1:0]  resp_rdata, wdata_drv;
    logic [NWL-1:0] wl;

    sram_array_seq #(.ADDR_W(AW), .DATA_W(DW), .PRE_CYC(1), .ACC_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .pre_b(pre_b), .wl(wl), .wr_en(wr_en), .wdata_drv(wdata_drv),
        .sae(sae), .bl_sense(bl_sense)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            acc_edges[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    logic [DW-1:0] model_rdata = '0;
    logic [AW-1:0] acc_addr = '0;
    logic [DW-1:0] acc_wdata = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Acceptance: push the expected response built from the bench model.
    always @(posedge clk) begin
        if (mon_en && rst_n && req_valid && req_ready) begin : accept
            exp_t e;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_edges.push_back(cyc);
            if (req_we) begin
                e.rdata = model_rdata;
                e.err   = VFY && (bl_sense != req_wdata);
                e.cyc   = cyc + (VFY ? 7 : 4);
            end else begin
                model_rdata = bl_sense;
                e.rdata = bl_sense;
                e.err   = 1'b0;
                e.cyc   = cyc + 4;
            end
            sb.push_back(e);
        end
    end

    // Per-cycle invariants and response compare, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin : mon
            exp_t e;
            chk("inv_pre_wl", !(pre_b == 1'b0 && wl != '0), 1);
            chk("inv_wr_sae", !(wr_en && sae), 1);
            chk("inv_onehot", $onehot0(wl), 1);
            if (wl != '0) chk("wl_addr", wl, 16'h1 << acc_addr);
            if (wr_en) chk("wdata_drv", wdata_drv, acc_wdata);
            if (resp_valid) begin
                chk("resp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", resp_err, e.err);
                end
            end
        end
    end

    // Called right after a negedge; returns at the negedge of cycle T+1.
    task automatic issue(input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] sense);
        int n = 0;
        bl_sense  = sense;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", n < 50, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset for two edges
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_pre_b", pre_b, 0);
        chk("rst_wl", wl, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Read addr 5
        issue(1'b0, 4'd5, '0, 32'hDEADBEEF);
        chk("rd_c1_pre_b", pre_b, 0);
        chk("rd_c1_wl", wl, 0);
        chk("rd_c1_ready", req_ready, 0);
        @(negedge clk);
        chk("rd_c2_wl", wl, 16'h0020);
        chk("rd_c2_sae", sae, 0);
        chk("rd_c2_pre_b", pre_b, 1);
        @(negedge clk);
        chk("rd_c3_wl", wl, 16'h0020);
        chk("rd_c3_sae", sae, 1);
        @(negedge clk);
        chk("rd_c4_valid", resp_valid, 1);
        chk("rd_c4_rdata", resp_rdata, 32'hDEADBEEF);
        chk("rd_c4_wl", wl, 0);
        @(negedge clk);
        chk("rd_c5_valid", resp_valid, 0);
        chk("rd_c5_ready", req_ready, 1);
        chk("rd_c5_rdata_hold", resp_rdata, 32'hDEADBEEF);

        // Write 0x12345678 to addr 15, then read addr 0
        issue(1'b1, 4'd15, 32'h1234_5678, 32'h1234_5678);
        chk("wr_c1_wr_en", wr_en, 0);
        @(negedge clk);
        chk("wr_c2_wr_en", wr_en, 1);
        chk("wr_c2_wl", wl, 16'h8000);
        chk("wr_c2_drv", wdata_drv, 32'h1234_5678);
        @(negedge clk);
        chk("wr_c3_wr_en", wr_en, 1);
        chk("wr_c3_wl", wl, 16'h8000);
        chk("wr_c3_sae", sae, 0);
        drain();
        chk("wr_rdata_unchanged", resp_rdata, 32'hDEADBEEF);
        chk("wr_drv_hold", wdata_drv, 32'h1234_5678);

        issue(1'b0, 4'd0, '0, 32'h0BAD_F00D);
        @(negedge clk);
        chk("rd0_wl", wl, 16'h0001);
        drain();
        chk("rd0_rdata", resp_rdata, 32'h0BAD_F00D);

        // Back-to-back reads with the address changing every cycle
        acc_edges.delete();
        bl_sense  = 32'hCAFE_0000;
        req_we    = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 23; i++) begin
            req_addr = AW'(i * 7 + 3);
            @(negedge clk);
        end
        req_valid = 1'b0;
        drain();
        chk("b2b_count", acc_edges.size() >= 4, 1);
        for (int k = 1; k < acc_edges.size(); k++)
            chk("b2b_gap", acc_edges[k] - acc_edges[k-1], 5);

        // Reset during the first ACC cycle of a write
        issue(1'b1, 4'd3, 32'h55AA_55AA, 32'h55AA_55AA);
        @(negedge clk);
        chk("mid_acc_wr_en", wr_en, 1);
        rst_n = 1'b0;
        @(negedge clk);
        sb.delete();
        model_rdata = '0;
        chk("mid_rst_wl", wl, 0);
        chk("mid_rst_wr_en", wr_en, 0);
        chk("mid_rst_ready", req_ready, 1);
        chk("mid_rst_rdata", resp_rdata, 0);
        chk("mid_rst_drv", wdata_drv, 0);
        chk("mid_rst_valid", resp_valid, 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("mid_rst_idle", req_ready, 1);

        // Write with mismatching verify data, then matching
        issue(1'b1, 4'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A4);
        drain();
        issue(1'b1, 4'd9, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        drain();
        chk("final_rdata", resp_rdata, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_array_seq.md
# sram_array_seq

Timing sequencer for the transistor-level 6T SRAM array built from the switch-level NMOS/PMOS models. It accepts one read or write request at a time over a valid/ready handshake. It drives the array's precharge, wordline, write-driver and sense-amp controls in a fixed, non-overlapping phase order, then returns a one-cycle response. It sits between the digital test harness and the array netlist in the transistor-level simulation.

## Interface

**Parameters**
- `ADDR_W`, default 4: row address width; `2**ADDR_W` wordlines.
- `DATA_W`, default 32: bits per row.
- `PRE_CYC`, default 1: precharge phase length in cycles (≥1).
- `ACC_CYC`, default 2: wordline/access phase length in cycles (≥1).

**Ports**
- `clk` input 1: sole clock; all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: sequencer can accept a request.
- `req_we` input 1: 1 = write, 0 = read.
- `req_addr` input ADDR_W: row address.
- `req_wdata` input DATA_W: write data.
- `resp_valid` output 1: one-cycle completion pulse; no backpressure.
- `resp_rdata` output DATA_W: read data; holds its value between reads.
- `resp_err` output 1: write-verify mismatch (see Configuration).
- `pre_b` output 1: active-low bitline precharge; drives the PMOS gates.
- `wl` output 2**ADDR_W: one-hot wordlines.
- `wr_en` output 1: write-driver enable.
- `wdata_drv` output DATA_W: write-driver data.
- `sae` output 1: sense-amp enable.
- `bl_sense` input DATA_W: sense-amp outputs from the array.

## Operation

- All outputs are registered.
- States are IDLE, PRE, ACC and RESP. A down-counter sized `$clog2(max(PRE_CYC,ACC_CYC)+1)` times PRE and ACC.
- **IDLE**
  - `req_ready`=1, `pre_b`=0 (bitlines held precharged), `wl`=0, `wr_en`=0, `sae`=0.
  - On `req_valid && req_ready`, latch `req_we`, `req_addr` and `req_wdata`, then go to PRE.
- **PRE**
  - `req_ready`=0, `pre_b`=0, `wl`=0.
  - Stays PRE_CYC cycles, then goes to ACC.
- **ACC**
  - `pre_b`=1 and `wl` = `1 << addr_q`.
  - Write: `wr_en`=1 and `wdata_drv` = `wdata_q` for all ACC_CYC cycles.
  - Read: `sae`=1 only in the last ACC cycle; `bl_sense` is captured into `resp_rdata` at the end of that cycle.
  - Stays ACC_CYC cycles, then goes to RESP.
- **RESP**
  - `resp_valid`=1 for exactly one cycle; `wl`=0, `pre_b`=0.
  - Next state is IDLE.
- **Non-overlap invariants** (checked every cycle)
  - `pre_b`=0 and `wl`≠0 never occur together.
  - `wr_en` and `sae` are never both 1.
  - `wl` has at most one hot bit.
- **Outputs on write requests**
  - `resp_rdata` is unchanged.
  - `wdata_drv` holds its last value outside ACC.
- A `req_valid` that arrives outside IDLE is ignored. The requester must hold it until `req_ready` is seen.
- **Reset** (`rst_n`=0 at a rising edge, in any state, including mid-ACC)
  - Next cycle: IDLE.
  - `wl`=0, `wr_en`=0, `sae`=0, `pre_b`=0, `req_ready`=1.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `wdata_drv`=0.
  - The in-flight request is dropped with no response.

## Timing

- Request accepted at edge T:
  - PRE covers cycles T+1 … T+PRE_CYC.
  - ACC covers cycles T+PRE_CYC+1 … T+PRE_CYC+ACC_CYC.
  - `resp_valid` is asserted in cycle T+PRE_CYC+ACC_CYC+1.
- Read latency is PRE_CYC+ACC_CYC+1 cycles from acceptance to `resp_valid`. With defaults, that is 4.
- `req_ready` returns in the cycle after RESP. Peak throughput is one request per PRE_CYC+ACC_CYC+2 cycles.
- `resp_rdata` is valid in the same cycle as `resp_valid` and remains stable afterwards until the next read completes.

## Configuration

- Macro: `SRAM_ARRAY_SEQ_WRITE_VERIFY_EN`.
- **Defined:** each write adds a verify pass after its ACC phase.
  - Sequence: PRE (PRE_CYC) → ACC as a read of the same row (ACC_CYC, `sae` in the last cycle) → RESP.
  - `resp_err` = (`bl_sense` ≠ `wdata_q`), valid with `resp_valid`.
  - Write latency becomes 2·(PRE_CYC+ACC_CYC)+1.
  - `resp_rdata` is unchanged by the verify read.
- **Undefined:** no verify pass and `resp_err` is tied to 0. Read and write latency are identical.

## Test plan

- **Reset:** hold `rst_n`=0 for 2 cycles, then release.
  - Required: `req_ready`=1, `pre_b`=0, `wl`=0, `resp_valid`=0, `resp_rdata`=0.
- **Read, defaults:** read at addr 5, accepted at edge 0, with `bl_sense`=32'hDEADBEEF.
  - `pre_b`=0 in cycle 1.
  - `wl`=16'h0020 in cycles 2–3; `sae`=1 in cycle 3 only.
  - `resp_valid`=1 in cycle 4 with `resp_rdata`=32'hDEADBEEF.
- **Write then read:** write 32'h1234_5678 to addr 15, then read addr 0.
  - Write: `wr_en`=1 and `wl`=16'h8000 for 2 cycles; `resp_rdata` unchanged at its resp.
  - Read: `wl`=16'h0001.
  - Invariant checker reports no overlap of `pre_b`=0 with `wl`≠0.
- **Back-to-back requests:** hold `req_valid`=1 continuously.
  - Acceptances occur exactly every 5 cycles.
  - A request presented while `req_ready`=0 is not latched early.
- **Reset mid-access:** assert `rst_n`=0 during the first ACC cycle of a write.
  - Next cycle: `wl`=0, `wr_en`=0, IDLE.
  - No `resp_valid` for the dropped request.
- **Write verify** (`SRAM_ARRAY_SEQ_WRITE_VERIFY_EN` defined): write 32'hA5A5A5A5, with the model returning 32'hA5A5A5A4 on the verify read.
  - `resp_valid` at cycle 7 with `resp_err`=1.
  - With matching data, `resp_err`=0.
